// File: rtl/pwm_ramp_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pwm_ramp_ctrl_pkg
//   Shared definitions for the PWM ramp sequencer: controller state encoding
//   and the default bus widths / reset period used by pwm_ramp_ctrl and its
//   period tracker.
//   Ports: none (package).
// -----------------------------------------------------------------------------
package pwm_ramp_ctrl_pkg;

  localparam int DEF_WIDTH_PERIOD = 16;
  localparam int DEF_WIDTH_DUTY   = 16;
  localparam int DEF_WIDTH_STEP   = 8;
  localparam int DEF_RST_PERIOD   = 1000;

  // Encodings are fixed so the state can be read back by software/debug.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_HOLD = 2'd2,
    ST_STOP = 2'd3
  } state_e;

endpackage

// File: rtl/pwm_ramp_ctrl_period_tracker.sv
// -----------------------------------------------------------------------------
// pwm_ramp_ctrl_period_tracker
//   Mirror of the pwm_core period counter. Runs in lockstep with the core
//   (same clock, same reset, same period input) and flags the last clock
//   cycle of every PWM period so upstream logic can update period/duty
//   exactly on a period boundary.
//   Ports:
//     clk       in   clock
//     reset_n   in   asynchronous, active-low reset
//     period_i  in   current PWM period (never 0)
//     tick_o    out  high on the last clk cycle of each PWM period
// -----------------------------------------------------------------------------
module pwm_ramp_ctrl_period_tracker
  import pwm_ramp_ctrl_pkg::*;
#(
  parameter int WIDTH_PERIOD = DEF_WIDTH_PERIOD
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [WIDTH_PERIOD-1:0] period_i,
  output logic                    tick_o
);

  logic [WIDTH_PERIOD-1:0] cnt_q;
  logic [WIDTH_PERIOD-1:0] cnt_d;

  // ">=" rather than "==" so a period shrinking under a running count still
  // wraps on the next cycle, exactly as pwm_core does.
  assign tick_o = (cnt_q >= period_i - WIDTH_PERIOD'(1));
  assign cnt_d  = tick_o ? '0 : cnt_q + WIDTH_PERIOD'(1);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_ramp_ctrl
//   Sequencer for one pwm_core channel. Accepts ramp commands (period, target
//   duty, step) over a valid/ready port and drives the core's period/duty.
//   Period and duty change only on the clock edge that ends a PWM period; duty
//   slews toward the target by a fixed step once per period.
//
//   Build option: define PWM_CTRL_SOFTSTOP_EN to ramp duty down to 0 (STOP
//   state) when enable drops; otherwise duty is forced to 0 on the next clk.
//
//   Ports:
//     clk          in   clock
//     reset_n      in   asynchronous, active-low reset
//     enable       in   channel enable; low forces shutdown
//     cmd_valid    in   command valid
//     cmd_ready    out  command accepted when cmd_valid && cmd_ready
//     cmd_period   in   new PWM period in clk cycles (0 treated as 1)
//     cmd_target   in   target duty in counts (> period means 100%)
//     cmd_step     in   duty change per PWM period (0 means jump)
//     period_o     out  to pwm_core.period
//     duty_o       out  to pwm_core.duty
//     period_tick  out  high on the last clk cycle of each PWM period
//     busy         out  high while ramping or soft-stopping
//     done         out  1-cycle pulse when duty_o reaches its target
// -----------------------------------------------------------------------------
module pwm_ramp_ctrl
  import pwm_ramp_ctrl_pkg::*;
#(
  parameter int WIDTH_PERIOD = DEF_WIDTH_PERIOD,
  parameter int WIDTH_DUTY   = DEF_WIDTH_DUTY,
  parameter int WIDTH_STEP   = DEF_WIDTH_STEP,
  parameter int RST_PERIOD   = DEF_RST_PERIOD
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [WIDTH_PERIOD-1:0] cmd_period,
  input  logic [WIDTH_DUTY-1:0]   cmd_target,
  input  logic [WIDTH_STEP-1:0]   cmd_step,
  output logic [WIDTH_PERIOD-1:0] period_o,
  output logic [WIDTH_DUTY-1:0]   duty_o,
  output logic                    period_tick,
  output logic                    busy,
  output logic                    done
);

  // One extra bit so |tgt - duty| never overflows near the top of the range.
  localparam int WX = WIDTH_DUTY + 1;

  state_e                  state_q, state_d;
  logic [WIDTH_PERIOD-1:0] period_q, period_d;
  logic [WIDTH_DUTY-1:0]   duty_q, duty_d;
  logic [WIDTH_PERIOD-1:0] pend_period_q, pend_period_d;
  logic [WIDTH_DUTY-1:0]   tgt_q, tgt_d;
  logic [WIDTH_STEP-1:0]   stp_q, stp_d;
  logic                    done_q, done_d;
  logic                    active_q;

  logic                    tick;
  logic                    accept;

  logic [WX-1:0]           duty_x, tgt_x, stp_x, diff_x;
  logic                    ramp_up;
  logic                    last_step;
  logic [WIDTH_DUTY-1:0]   slew_duty;

  pwm_ramp_ctrl_period_tracker #(
    .WIDTH_PERIOD(WIDTH_PERIOD)
  ) u_tracker (
    .clk     (clk),
    .reset_n (reset_n),
    .period_i(period_q),
    .tick_o  (tick)
  );

  // active_q holds off command acceptance until the first edge after reset,
  // so cmd_ready reads 0 throughout reset regardless of enable.
  assign cmd_ready   = active_q && enable &&
                       ((state_q == ST_IDLE) || (state_q == ST_HOLD));
  assign accept      = cmd_valid && cmd_ready;
  assign busy        = (state_q == ST_RAMP) || (state_q == ST_STOP);
  assign done        = done_q && enable;
  assign period_o    = period_q;
  assign duty_o      = duty_q;
  assign period_tick = tick;

  // Slew arithmetic. The final step snaps to the target, so the plain
  // WIDTH_DUTY add/subtract below is only used when it cannot pass tgt.
  assign duty_x    = WX'(duty_q);
  assign tgt_x     = WX'(tgt_q);
  assign stp_x     = WX'(stp_q);
  assign ramp_up   = (tgt_x >= duty_x);
  assign diff_x    = ramp_up ? (tgt_x - duty_x) : (duty_x - tgt_x);
  assign last_step = (stp_q == '0) || (diff_x <= stp_x);
  assign slew_duty = ramp_up ? (duty_q + WIDTH_DUTY'(stp_q))
                             : (duty_q - WIDTH_DUTY'(stp_q));

`ifdef PWM_CTRL_SOFTSTOP_EN
  logic [WIDTH_DUTY-1:0] stop_dec;
  logic [WIDTH_DUTY-1:0] stop_duty;

  // Soft stop always makes progress even if the last command was a jump.
  assign stop_dec  = (stp_q == '0) ? WIDTH_DUTY'(1) : WIDTH_DUTY'(stp_q);
  assign stop_duty = (duty_q <= stop_dec) ? '0 : (duty_q - stop_dec);
`endif

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d       = state_q;
    period_d      = period_q;
    duty_d        = duty_q;
    pend_period_d = pend_period_q;
    tgt_d         = tgt_q;
    stp_d         = stp_q;
    done_d        = 1'b0;

    case (state_q)
      // A tick on the accept cycle is ignored: the command only becomes
      // active in RAMP, so its first effect is at the following tick.
      ST_IDLE, ST_HOLD: begin
        if (accept) begin
          pend_period_d = (cmd_period == '0) ? WIDTH_PERIOD'(1) : cmd_period;
          tgt_d         = cmd_target;
          stp_d         = cmd_step;
          state_d       = ST_RAMP;
        end
      end

      ST_RAMP: begin
        if (tick) begin
          period_d = pend_period_q;
          if (last_step) begin
            duty_d  = tgt_q;
            done_d  = 1'b1;
            state_d = ST_HOLD;
          end else begin
            duty_d  = slew_duty;
          end
        end
      end

`ifdef PWM_CTRL_SOFTSTOP_EN
      // Ignores enable: once started, a soft stop always runs to IDLE.
      ST_STOP: begin
        if (duty_q == '0) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          duty_d = stop_duty;
          if (stop_duty == '0) begin
            state_d = ST_IDLE;
          end
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Shutdown overrides whatever the state logic chose this cycle and
    // discards any latched command.
`ifdef PWM_CTRL_SOFTSTOP_EN
    if (!enable && ((state_q == ST_RAMP) || (state_q == ST_HOLD))) begin
      state_d  = ST_STOP;
      period_d = period_q;
      duty_d   = duty_q;
      done_d   = 1'b0;
    end
`else
    if (!enable) begin
      state_d  = ST_IDLE;
      period_d = period_q;
      duty_d   = '0;
      done_d   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      period_q      <= WIDTH_PERIOD'(RST_PERIOD);
      duty_q        <= '0;
      pend_period_q <= WIDTH_PERIOD'(RST_PERIOD);
      tgt_q         <= '0;
      stp_q         <= '0;
      done_q        <= 1'b0;
      active_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      period_q      <= period_d;
      duty_q        <= duty_d;
      pend_period_q <= pend_period_d;
      tgt_q         <= tgt_d;
      stp_q         <= stp_d;
      done_q        <= done_d;
      active_q      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pwm_ramp_ctrl
//   Directed bench for pwm_ramp_ctrl driving a behavioural pwm_core
//   (lockstep period counter, output high while count < duty).
//   A table of ramp commands is applied back to back with hand-computed duty
//   sequences, followed by hand-written sequences for boundary-coincident
//   accept, enable drop mid-ramp (both PWM_CTRL_SOFTSTOP_EN builds) and
//   reset mid-ramp.
// -----------------------------------------------------------------------------
module tb_pwm_ramp_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_period;
  logic [15:0] cmd_target;
  logic [7:0]  cmd_step;
  logic [15:0] period_o;
  logic [15:0] duty_o;
  logic        period_tick;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  pwm_ramp_ctrl #(
    .WIDTH_PERIOD(16),
    .WIDTH_DUTY  (16),
    .WIDTH_STEP  (8),
    .RST_PERIOD  (1000)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_period (cmd_period),
    .cmd_target (cmd_target),
    .cmd_step   (cmd_step),
    .period_o   (period_o),
    .duty_o     (duty_o),
    .period_tick(period_tick),
    .busy       (busy),
    .done       (done)
  );

  // Behavioural pwm_core.
  logic [15:0] core_cnt;
  logic        pwm_out;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) core_cnt <= 16'd0;
    else          core_cnt <= (core_cnt >= period_o - 16'd1) ? 16'd0 : core_cnt + 16'd1;
  end
  assign pwm_out = (core_cnt < duty_o);

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0]      period;
    logic [15:0]      target;
    logic [7:0]       step;
    logic [1:0]       n;          // number of ticks to reach target
    logic [2:0][15:0] seq;        // duty_o after each tick
    logic [15:0]      exp_period; // period_o after the first tick
    logic [7:0]       win;        // pwm window length in clks (0: skip)
    logic [7:0]       exp_hi;     // expected high cycles in the window
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mk(input logic [15:0] p, input logic [15:0] t,
                              input logic [7:0] s, input logic [1:0] n,
                              input logic [15:0] s0, input logic [15:0] s1,
                              input logic [15:0] s2, input logic [15:0] ep,
                              input logic [7:0] w, input logic [7:0] h);
    vec_t r;
    r.period     = p;
    r.target     = t;
    r.step       = s;
    r.n          = n;
    r.seq[0]     = s0;
    r.seq[1]     = s1;
    r.seq[2]     = s2;
    r.exp_period = ep;
    r.win        = w;
    r.exp_hi     = h;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance (at negedges) until period_tick is high; bounded.
  task automatic wait_tick(output int n);
    n = 0;
    while (!period_tick && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!period_tick) check("tick_timeout", {31'd0, period_tick}, 32'd1);
  endtask

  task automatic step_expect(input string name, input logic [15:0] exp);
    int n;
    wait_tick(n);
    @(negedge clk);
    check(name, {16'd0, duty_o}, {16'd0, exp});
  endtask

  task automatic send_cmd(input logic [15:0] p, input logic [15:0] t, input logic [7:0] s);
    int n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("cmd_ready_timeout", {31'd0, cmd_ready}, 32'd1);
    cmd_period = p;
    cmd_target = t;
    cmd_step   = s;
    cmd_valid  = 1'b1;
    @(negedge clk);
    cmd_valid  = 1'b0;
  endtask

  task automatic measure(input int win, output int hi, output int ticks);
    hi    = 0;
    ticks = 0;
    for (int c = 0; c < win; c++) begin
      if (pwm_out)     hi++;
      if (period_tick) ticks++;
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int hi;
    int ticks;
    vec_t v;

    reset_n    = 1'b0;
    enable     = 1'b0;
    cmd_valid  = 1'b0;
    cmd_period = 16'd0;
    cmd_target = 16'd0;
    cmd_step   = 8'd0;

    //            period   target    step  n    seq0      seq1      seq2   exp_p  win    hi
    vecs[0] = mk(16'd10, 16'd8,     8'd3,   2'd3, 16'd3,    16'd6,    16'd8, 16'd10, 8'd40, 8'd32);
    vecs[1] = mk(16'd10, 16'd2,     8'd0,   2'd1, 16'd2,    16'd0,    16'd0, 16'd10, 8'd0,  8'd0);
    vecs[2] = mk(16'd10, 16'd9,     8'd4,   2'd2, 16'd6,    16'd9,    16'd0, 16'd10, 8'd0,  8'd0);
    vecs[3] = mk(16'd10, 16'd1,     8'd5,   2'd2, 16'd4,    16'd1,    16'd0, 16'd10, 8'd0,  8'd0);
    vecs[4] = mk(16'd0,  16'd5,     8'd0,   2'd1, 16'd5,    16'd0,    16'd0, 16'd1,  8'd4,  8'd4);
    vecs[5] = mk(16'd20, 16'd12,    8'd7,   2'd1, 16'd12,   16'd0,    16'd0, 16'd20, 8'd0,  8'd0);
    vecs[6] = mk(16'd20, 16'd4,     8'd7,   2'd2, 16'd5,    16'd4,    16'd0, 16'd20, 8'd0,  8'd0);
    vecs[7] = mk(16'd10, 16'hFF80,  8'd0,   2'd1, 16'hFF80, 16'd0,    16'd0, 16'd10, 8'd0,  8'd0);
    vecs[8] = mk(16'd10, 16'hFFFF,  8'd255, 2'd1, 16'hFFFF, 16'd0,    16'd0, 16'd10, 8'd40, 8'd40);
    vecs[9] = mk(16'd10, 16'hFF00,  8'd128, 2'd2, 16'hFF7F, 16'hFF00, 16'd0, 16'd10, 8'd0,  8'd0);

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst_period",  {16'd0, period_o}, 32'd1000);
    check("rst_duty",    {16'd0, duty_o},   32'd0);
    check("rst_ready",   {31'd0, cmd_ready}, 32'd0);
    check("rst_busy",    {31'd0, busy},     32'd0);
    check("rst_done",    {31'd0, done},     32'd0);
    check("rst_tick",    {31'd0, period_tick}, 32'd0);
    reset_n = 1'b1;
    enable  = 1'b1;
    @(negedge clk);
    check("idle_ready",  {31'd0, cmd_ready}, 32'd1);
    check("idle_busy",   {31'd0, busy},     32'd0);

    // ---- table-driven ramps, each starting from the previous hold value ----
    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      send_cmd(v.period, v.target, v.step);
      check($sformatf("v%0d_busy", i),  {31'd0, busy},      32'd1);
      check($sformatf("v%0d_ready", i), {31'd0, cmd_ready}, 32'd0);
      for (int k = 0; k < int'(v.n); k++) begin
        step_expect($sformatf("v%0d_duty%0d", i, k), v.seq[k]);
        check($sformatf("v%0d_period%0d", i, k), {16'd0, period_o}, {16'd0, v.exp_period});
        if (k < int'(v.n) - 1) begin
          check($sformatf("v%0d_nodone%0d", i, k), {31'd0, done},      32'd0);
          check($sformatf("v%0d_ramprdy%0d", i, k), {31'd0, cmd_ready}, 32'd0);
        end else begin
          check($sformatf("v%0d_done", i),     {31'd0, done}, 32'd1);
          check($sformatf("v%0d_holdbusy", i), {31'd0, busy}, 32'd0);
        end
      end
      @(negedge clk);
      check($sformatf("v%0d_done_1cyc", i), {31'd0, done}, 32'd0);
      if (v.win != 8'd0) begin
        measure(int'(v.win), hi, ticks);
        check($sformatf("v%0d_pwm_high", i),  hi,    {24'd0, v.exp_hi});
        check($sformatf("v%0d_pwm_ticks", i), ticks, 32'd4);
      end
    end

    // ---- accept on a tick cycle: no change at that tick, change at the next ----
    // Holding at 0xFF00, period 10.
    wait_tick(lat);
    send_cmd(16'd10, 16'h0040, 8'd0);
    check("coinc_nochg",     {16'd0, duty_o}, 32'h0000FF00);
    check("coinc_busy",      {31'd0, busy},   32'd1);
    wait_tick(lat);
    check("coinc_latency",   lat, 32'd9);
    check("coinc_pre_tick",  {16'd0, duty_o}, 32'h0000FF00);
    @(negedge clk);
    check("coinc_applied",   {16'd0, duty_o}, 32'h00000040);
    check("coinc_done",      {31'd0, done},   32'd1);
    @(negedge clk);

    // ---- drop enable mid-ramp at duty 6 ----
    send_cmd(16'd10, 16'd0, 8'd0);
    step_expect("prep_zero", 16'd0);
    @(negedge clk);
    send_cmd(16'd10, 16'd12, 8'd3);
    step_expect("abort_r3", 16'd3);
    step_expect("abort_r6", 16'd6);
    enable = 1'b0;
    @(negedge clk);
`ifdef PWM_CTRL_SOFTSTOP_EN
    check("stop_busy0",  {31'd0, busy},      32'd1);
    check("stop_duty0",  {16'd0, duty_o},    32'd6);
    check("stop_ready",  {31'd0, cmd_ready}, 32'd0);
    step_expect("stop_duty1", 16'd3);
    check("stop_busy1",  {31'd0, busy},      32'd1);
    check("stop_done1",  {31'd0, done},      32'd0);
    step_expect("stop_duty2", 16'd0);
    check("stop_idle",   {31'd0, busy},      32'd0);
    check("stop_done2",  {31'd0, done},      32'd0);
    check("stop_period", {16'd0, period_o},  32'd10);
`else
    check("off_duty",    {16'd0, duty_o},    32'd0);
    check("off_busy",    {31'd0, busy},      32'd0);
    check("off_ready",   {31'd0, cmd_ready}, 32'd0);
    check("off_done",    {31'd0, done},      32'd0);
    check("off_period",  {16'd0, period_o},  32'd10);
    step_expect("off_stays_zero", 16'd0);
`endif
    enable = 1'b1;
    #1;
    check("reenable_ready", {31'd0, cmd_ready}, 32'd1);

    // ---- reset mid-ramp at duty 4 ----
    @(negedge clk);
    send_cmd(16'd10, 16'd8, 8'd2);
    step_expect("prerst_r2", 16'd2);
    step_expect("prerst_r4", 16'd4);
    #2;
    reset_n = 1'b0;
    #1;
    check("mrst_period", {16'd0, period_o},  32'd1000);
    check("mrst_duty",   {16'd0, duty_o},    32'd0);
    check("mrst_busy",   {31'd0, busy},      32'd0);
    check("mrst_ready",  {31'd0, cmd_ready}, 32'd0);
    check("mrst_done",   {31'd0, done},      32'd0);
    check("mrst_pwm",    {31'd0, pwm_out},   32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("post_rst_duty",  {16'd0, duty_o},    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
